axis_multich_downmix: RTL and testbench
=======================================

// Module: axis_multich_downmix
// PURPOSE
//  Parametrised N-channel to mono downmixer on AXI-Stream. Input carries channel-interleaved beats (ch0..chN-1).
//  Each complete group is averaged, requantised to OUT_W bits and emitted MSB-aligned in the output lane.
//  A 2-entry output queue decouples backpressure. Sits between the I2S/ADC receiver and the mono DSP/DMA path.
// PARAMETERS
//  NUM_CH      2   channels per group; power of two, 1..16 (1 = pure requantiser)
//  IN_W        24  signed sample width, taken from s_axis_data[IN_W-1:0]
//  IN_LANE_W   32  input tdata width, >= IN_W
//  OUT_W       12  signed mono width, <= IN_W
//  OUT_LANE_W  16  output tdata width, >= OUT_W
//  ROUND_MODE  0   0 = truncate (floor), 1 = round half up
// PORTS
//  clk            in   1           clock
//  rst            in   1           synchronous, active-high reset
//  s_axis_data    in   IN_LANE_W   interleaved channel sample
//  s_axis_valid   in   1           input valid
//  s_axis_ready   out  1           input ready
//  s_axis_last    in   1           end of frame; legal only on channel NUM_CH-1
//  m_axis_data    out  OUT_LANE_W  {mono[OUT_W-1:0], (OUT_LANE_W-OUT_W) zeros}
//  m_axis_valid   out  1           output valid
//  m_axis_ready   in   1           output ready
//  m_axis_last    out  1           set on mono word from the group that carried s_axis_last
//  err_misalign   out  1           1-cycle pulse: s_axis_last seen on channel index != NUM_CH-1
// BEHAVIOUR
//  - Reset: ch_idx=0, acc=0, queue empty; m_axis_valid=0, m_axis_data=0, m_axis_last=0, err_misalign=0, s_axis_ready=1 in the cycle after reset deasserts.
//    Reset mid-group or with queued words discards everything; no output after reset until a new full group arrives.
//  - Handshake: beat accepted when s_axis_valid & s_axis_ready. s_axis_ready = (queue count < 2), registered. No combinational ready->ready path.
//  - Output rules: m_axis_valid/data/last hold stable until m_axis_ready. Words leave in arrival order.
//  - Accumulate: ch_idx counts 0..NUM_CH-1 and wraps to 0. Channel 0 loads acc = sext(sample). Later channels add to acc.
//    ACC_W = IN_W + log2(NUM_CH).
//  - Final channel: sum = acc + sample. SHIFT = log2(NUM_CH) + IN_W - OUT_W.
//    res = (sum + (ROUND_MODE ? 2^(SHIFT-1) : 0)) >>> SHIFT, arithmetic shift, OUT_W+1 bits. Rounding term is 0 when SHIFT = 0.
//    The result is pushed into the queue in the same cycle. m_axis_valid rises the next cycle: latency 1 clk from final-beat accept.
//  - Throughput: one mono word per NUM_CH input beats at full rate when m_axis_ready=1.
//  - Queue: push and pop in the same cycle are both honoured and count is unchanged. A push at count 2 cannot occur because ready=0.
//  - Misalignment: s_axis_last accepted with ch_idx != NUM_CH-1 drops the partial group, sets ch_idx=0 and pulses err_misalign. No output word is produced.
//  - s_axis_last accepted on the final channel sets the pushed word's last flag and resets ch_idx to 0 (normal wrap).
// CONFIGURATION
//  - DOWNMIX_SAT_EN defined: res outside [-2^(OUT_W-1), 2^(OUT_W-1)-1] clamps to the nearest bound.
//  - DOWNMIX_SAT_EN undefined: low OUT_W bits of res are used, so overflow wraps.
// STRUCTURE
//  - Package downmix_pkg: clog2 function; ROUND_TRUNC=0 and ROUND_HALF_UP=1 constants; elaboration checks on the parameter constraints above.
//  - Sub-module axis_fifo2: 2-entry registered queue, width OUT_W+1 (data + last). Exposes count, push, pop and head outputs.
// TESTING (NUM_CH=2, IN_W=24, OUT_W=12, OUT_LANE_W=16 unless stated)
//  1. ch0=0x100000, ch1=0x100000, trunc -> m_axis_data=0x1000 one cycle after ch1 accepted; m_axis_last follows ch1 last.
//  2. ch0=ch1=0xFFF000 (-4096), trunc -> 0xFFF0. ch0=0x001000, ch1=0: ROUND_MODE=0 -> 0x0000; ROUND_MODE=1 -> 0x0010.
//  3. ROUND_MODE=1, ch0=ch1=0x7FFFFF -> with DOWNMIX_SAT_EN 0x7FF0; without it 0x8000.
//  4. Misalign: single beat with last=1 on ch0 -> no output, err_misalign high 1 cycle. Next pair 0x100000/0x100000 -> 0x1000.
//  5. Backpressure: m_axis_ready=0, continuous valid input.
//     -> s_axis_ready falls after the 2nd group (4 beats). Release gives 2 words in order with no loss or duplication.
//     Random ready at 50% over 1000 groups matches the reference model.
//  6. Reset asserted for 1 cycle after ch0 of a group and with 1 queued word.
//     -> m_axis_valid=0 next cycle; the following 2 beats form a fresh group.

Source files
------------

// File: rtl/downmix_pkg.sv
// downmix_pkg: shared constants, log2 helper and parameter legality check for the downmixer
package downmix_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic bit params_ok(input int num_ch, input int in_w, input int in_lane_w,
                                     input int out_w, input int out_lane_w, input int round_mode);
        return num_ch >= 1 && num_ch <= 16 && (num_ch & (num_ch - 1)) == 0 &&
               in_lane_w >= in_w && out_w >= 2 && out_w <= in_w && out_lane_w >= out_w &&
               (round_mode == ROUND_TRUNC || round_mode == ROUND_HALF_UP);
    endfunction

endpackage

// File: rtl/axis_fifo2.sv
// axis_fifo2: 2-entry registered queue; head is always the oldest entry
module axis_fifo2 #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [1:0]   count,
    output logic         valid,
    output logic [W-1:0] head
);

    logic [W-1:0] tail;
    logic [1:0]   wr;

    assign wr    = count - 2'(pop);
    assign valid = count != 2'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (pop) head <= tail;
            if (push && wr == 2'd0) head <= din;
            if (push && wr != 2'd0) tail <= din;
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/axis_multich_downmix.sv
// axis_multich_downmix: N-channel interleaved AXI-Stream to mono averaging downmixer.
// Define DOWNMIX_SAT_EN to clamp out-of-range results instead of wrapping.
module axis_multich_downmix
    import downmix_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int IN_W       = 24,
    parameter int IN_LANE_W  = 32,
    parameter int OUT_W      = 12,
    parameter int OUT_LANE_W = 16,
    parameter int ROUND_MODE = ROUND_TRUNC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_LANE_W-1:0]  s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic [OUT_LANE_W-1:0] m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last,
    output logic                  err_misalign
);

    localparam int LOG_CH = clog2(NUM_CH);
    localparam int ACC_W  = IN_W + LOG_CH;
    localparam int SHIFT  = LOG_CH + IN_W - OUT_W;
    localparam int IDX_W  = LOG_CH > 0 ? LOG_CH : 1;
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);
    localparam logic signed [ACC_W:0] RND =
        (ROUND_MODE == ROUND_HALF_UP && SHIFT > 0) ? (ACC_W+1)'(1) << (SHIFT - 1) : '0;

    if (!params_ok(NUM_CH, IN_W, IN_LANE_W, OUT_W, OUT_LANE_W, ROUND_MODE)) begin : g_bad_params
        $error("axis_multich_downmix: illegal parameter combination");
    end

    logic [IDX_W-1:0]        ch_idx;
    logic signed [ACC_W-1:0] acc, smp, sum;
    logic signed [ACC_W:0]   rsum;
    logic signed [OUT_W:0]   res;
    logic [OUT_W-1:0]        mono;
    logic [OUT_W:0]          head;
    logic [1:0]              count;
    logic                    accept, final_ch, push, pop, misalign, unused_bits;

    assign accept   = s_axis_valid & s_axis_ready;
    assign final_ch = ch_idx == LAST_CH;
    assign push     = accept & final_ch;
    assign misalign = accept & s_axis_last & ~final_ch;
    assign pop      = m_axis_valid & m_axis_ready;

    // channel 0 starts a fresh sum, so a 1-channel build degenerates to a requantiser
    assign smp  = ACC_W'($signed(s_axis_data[IN_W-1:0]));
    assign sum  = (ch_idx == '0 ? '0 : acc) + smp;
    assign rsum = (ACC_W+1)'(sum) + RND;
    assign res  = (OUT_W+1)'(rsum >>> SHIFT);

`ifdef DOWNMIX_SAT_EN
    assign mono = (res[OUT_W] != res[OUT_W-1])
                ? (res[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}})
                : res[OUT_W-1:0];
`else
    assign mono = res[OUT_W-1:0];
`endif

    assign unused_bits = ^{s_axis_data >> IN_W, res[OUT_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_idx       <= '0;
            acc          <= '0;
            err_misalign <= 1'b0;
            s_axis_ready <= 1'b1;
        end else begin
            if (accept) begin
                ch_idx <= (final_ch | s_axis_last) ? '0 : ch_idx + IDX_W'(1);
                acc    <= sum;
            end
            err_misalign <= misalign;
            s_axis_ready <= (count + 2'(push) - 2'(pop)) < 2'd2;
        end
    end

    axis_fifo2 #(.W(OUT_W + 1)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({s_axis_last, mono}),
        .count (count),
        .valid (m_axis_valid),
        .head  (head)
    );

    assign m_axis_last = head[OUT_W];
    assign m_axis_data = OUT_LANE_W'(head[OUT_W-1:0]) << (OUT_LANE_W - OUT_W);

endmodule

// File: tb/tb_axis_multich_downmix.sv
// tb_axis_multich_downmix: directed and randomized-backpressure checks of truncating and rounding builds
module tb_axis_multich_downmix;

    localparam int SHIFT = 13;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
    logic        rdy0, vld0, lst0, err0, rdy1, vld1, lst1, err1;
    logic [15:0] dat0, dat1;

    int  passed = 0, total = 0;
    bit  started = 1'b0, err_pend = 1'b0, rand_en = 1'b0;
    longint gsum = 0;
    int  gcnt = 0;
    logic [12:0] q0[$], q1[$];

    always #5 clk = ~clk;

    axis_multich_downmix #(.NUM_CH(2), .IN_W(24), .IN_LANE_W(32), .OUT_W(12), .OUT_LANE_W(16), .ROUND_MODE(0)) dut (
        .clk(clk), .rst(rst), .s_axis_data(s_data), .s_axis_valid(s_valid), .s_axis_ready(rdy0),
        .s_axis_last(s_last), .m_axis_data(dat0), .m_axis_valid(vld0), .m_axis_ready(m_ready),
        .m_axis_last(lst0), .err_misalign(err0));

    axis_multich_downmix #(.NUM_CH(2), .IN_W(24), .IN_LANE_W(32), .OUT_W(12), .OUT_LANE_W(16), .ROUND_MODE(1)) dut_r (
        .clk(clk), .rst(rst), .s_axis_data(s_data), .s_axis_valid(s_valid), .s_axis_ready(rdy1),
        .s_axis_last(s_last), .m_axis_data(dat1), .m_axis_valid(vld1), .m_axis_ready(m_ready),
        .m_axis_last(lst1), .err_misalign(err1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // mean of the pair, floor-divided down to 12 bits, then clamped or wrapped
    function automatic logic [11:0] model_mono(input longint sum, input bit half_up);
        longint r, m;
        r = sum + (half_up ? longint'(1) << (SHIFT - 1) : longint'(0));
        m = ((r % 8192) + 8192) % 8192;
        r = (r - m) / 8192;
`ifdef DOWNMIX_SAT_EN
        if (r > 2047) r = 2047;
        if (r < -2048) r = -2048;
`endif
        return r[11:0];
    endfunction

    always @(negedge clk) begin
        bit mrdy;
        longint smp;
        mrdy = q0.size() < 2;
        if (started) begin
            chk("valid0", vld0, q0.size() != 0);
            chk("valid1", vld1, q1.size() != 0);
            chk("ready0", rdy0, mrdy);
            chk("ready1", rdy1, q1.size() < 2);
            chk("err0", err0, err_pend);
            chk("err1", err1, err_pend);
            if (vld0 && q0.size() != 0) chk("word0", {lst0, dat0}, {q0[0], 4'h0});
            if (vld1 && q1.size() != 0) chk("word1", {lst1, dat1}, {q1[0], 4'h0});
            if (vld0 && m_ready && q0.size() != 0) void'(q0.pop_front());
            if (vld1 && m_ready && q1.size() != 0) void'(q1.pop_front());
        end
        err_pend = 1'b0;
        if (rst) begin
            started = 1'b1;
            q0.delete();
            q1.delete();
            gcnt = 0;
        end else if (started && s_valid && mrdy) begin
            smp  = longint'($signed(s_data[23:0]));
            gsum = (gcnt == 0) ? smp : gsum + smp;
            gcnt++;
            if (gcnt == 2) begin
                q0.push_back({s_last, model_mono(gsum, 1'b0)});
                q1.push_back({s_last, model_mono(gsum, 1'b1)});
                gcnt = 0;
            end else if (s_last) begin
                err_pend = 1'b1;
                gcnt = 0;
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic l);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        while (!rdy0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_en) m_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", vld0, 1'b0);
        chk("rst_data", dat0, 16'h0000);
        chk("rst_last", lst0, 1'b0);
        chk("rst_err", err0, 1'b0);
        chk("rst_ready", rdy0, 1'b1);

        send(32'h0010_0000, 1'b0);
        send(32'h0010_0000, 1'b1);
        chk("t1_valid", vld0, 1'b1);
        chk("t1_data", dat0, 16'h1000);
        chk("t1_last", lst0, 1'b1);
        @(posedge clk); #1;

        send(32'h00FF_F000, 1'b0);
        send(32'h00FF_F000, 1'b0);
        chk("t2_neg", dat0, 16'hFFF0);
        chk("t2_neg_last", lst0, 1'b0);
        send(32'h0000_1000, 1'b0);
        send(32'h0000_0000, 1'b0);
        chk("t2_trunc", dat0, 16'h0000);
        chk("t2_round", dat1, 16'h0010);

        send(32'h007F_FFFF, 1'b0);
        send(32'h007F_FFFF, 1'b0);
        chk("t3_trunc", dat0, 16'h7FF0);
`ifdef DOWNMIX_SAT_EN
        chk("t3_round_sat", dat1, 16'h7FF0);
`else
        chk("t3_round_wrap", dat1, 16'h8000);
`endif

        send(32'h0000_0000, 1'b1);
        chk("t4_err_hi", err0, 1'b1);
        chk("t4_no_word", vld0, 1'b0);
        @(posedge clk); #1;
        chk("t4_err_lo", err0, 1'b0);
        send(32'h0010_0000, 1'b0);
        send(32'h0010_0000, 1'b0);
        chk("t4_next", dat0, 16'h1000);

        @(posedge clk); #1;
        m_ready = 1'b0;
        send(32'h0010_0000, 1'b0);
        send(32'h0010_0000, 1'b0);
        chk("t5_ready_mid", rdy0, 1'b1);
        send(32'h0020_0000, 1'b0);
        send(32'h0020_0000, 1'b0);
        chk("t5_ready_low", rdy0, 1'b0);
        s_valid = 1'b1;
        s_data  = 32'h0030_0000;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_stalled", rdy0, 1'b0);
        chk("t5_hold", dat0, 16'h1000);
        m_ready = 1'b1;
        @(posedge clk); #1;
        chk("t5_second", dat0, 16'h2000);
        send(32'h0030_0000, 1'b0);
        send(32'h0030_0000, 1'b1);
        chk("t5_third", dat0, 16'h3000);
        chk("t5_third_last", lst0, 1'b1);
        @(posedge clk); #1;

        m_ready = 1'b0;
        send(32'h0010_0000, 1'b0);
        send(32'h0010_0000, 1'b0);
        send(32'h0004_0000, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_valid", vld0, 1'b0);
        chk("t6_ready", rdy0, 1'b1);
        send(32'h0010_0000, 1'b0);
        send(32'h0010_0000, 1'b0);
        chk("t6_fresh_valid", vld0, 1'b1);
        chk("t6_fresh_data", dat0, 16'h1000);
        m_ready = 1'b1;
        @(posedge clk); #1;

        rand_en = 1'b1;
        for (int g = 0; g < 1000; g++) begin
            if ($urandom_range(0, 49) == 0) send($urandom, 1'b1);
            send($urandom, 1'b0);
            send($urandom, ($urandom_range(0, 7) == 0));
        end
        rand_en = 1'b0;
        @(posedge clk); #2;
        m_ready = 1'b1;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", q0.size() + q1.size(), 0);
        @(posedge clk); #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
